// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one byte
// plus odd parity and stop on device clock falls, then checks the device ACK.
module ps2_host_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_ps2,
    input  logic                  ps2_data_in,
    output logic                  clk_ps2_drive_low,
    output logic                  ps2_data_drive_low,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_start,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  tx_error,
    output logic [2:0]            o_dbg_state
);

    localparam int SHIFT_W = DATA_WIDTH + 2;
    localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = $clog2(SHIFT_W + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_REL, S_DONE, S_ERROR
    } state_t;

    state_t               r_state;
    logic                 r_clk_s1, r_clk_s2, r_clk_s3;
    logic                 r_dat_s1, r_dat_s2;
    logic [SHIFT_W-1:0]   r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [INH_W-1:0]     r_inh_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_clk_drv, r_dat_drv;
    logic                 r_busy, r_done, r_error;

    logic                 w_fall;
    logic                 w_timeout;

    assign w_fall    = ~r_clk_s2 & r_clk_s3;
    assign w_timeout = (r_to_cnt == TO_LAST);

    assign clk_ps2_drive_low  = r_clk_drv;
    assign ps2_data_drive_low = r_dat_drv;
    assign busy               = r_busy;
    assign tx_done            = r_done;
    assign tx_error           = r_error;
    assign o_dbg_state        = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            // Synchronizers start at the idle (pulled-up) level so no false fall appears.
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_s3  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_drv <= 1'b0;
            r_dat_drv <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_clk_s1 <= clk_ps2;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data_in;
            r_dat_s2 <= r_dat_s1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shift   <= {1'b1, ~^tx_data, tx_data};
                        r_bit_cnt <= '0;
                        r_inh_cnt <= '0;
                        r_clk_drv <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_dat_drv <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    r_clk_drv <= 1'b0;
                    r_to_cnt  <= '0;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (w_timeout) begin
                        r_clk_drv <= 1'b0;
                        r_dat_drv <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_fall) begin
                            r_dat_drv <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[SHIFT_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_LAST) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_timeout || (w_fall && r_dat_s2)) begin
                        r_clk_drv <= 1'b0;
                        r_dat_drv <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_fall) begin
                            r_state <= S_WAIT_REL;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (w_timeout) begin
                        r_clk_drv <= 1'b0;
                        r_dat_drv <= 1'b0;
                        r_error   <= 1'b1;
                        r_state   <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_clk_s2 && r_dat_s2) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_clk_drv <= 1'b0;
                    r_dat_drv <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the host
// and the captured frames are compared against a byte-to-frame reference function.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       clk_ps2_drive_low, ps2_data_drive_low;
    logic       busy, tx_done, tx_error;
    logic [2:0] dbg_state;
    logic       clk_line, data_line;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    bit pend = 1'b0;

    // Open-drain bus: a line is high only when neither side pulls it low.
    assign clk_line  = ~clk_ps2_drive_low & dev_clk;
    assign data_line = ~ps2_data_drive_low & dev_data;

    ps2_host_tx #(
        .DATA_WIDTH(8),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_ps2(clk_line),
        .ps2_data_in(data_line),
        .clk_ps2_drive_low(clk_ps2_drive_low),
        .ps2_data_drive_low(ps2_data_drive_low),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .busy(busy),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Pulse bookkeeping; after any done/error pulse busy must be low on the next cycle.
    always @(negedge clk) begin
        if (pend) begin
            chk("busy_drop_after_pulse", busy, 0);
            pend = 1'b0;
        end
        if (tx_done)  done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (tx_done || tx_error) pend = 1'b1;
    end

    task automatic start_and_inhibit(input logic [7:0] b, input bit glitch);
        int hi;
        int drise;
        hi = 0;
        drise = 0;
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (clk_ps2_drive_low === 1'b1 && hi < INH + 50) begin
            hi++;
            if (drise == 0 && ps2_data_drive_low === 1'b1) drise = hi;
            if (glitch && hi == 5) begin
                tx_data  = ~b;
                tx_start = 1'b1;
            end
            if (glitch && hi == 6) tx_start = 1'b0;
            @(negedge clk);
        end
        chk("inhibit_len", hi, INH + 1);
        chk("start_bit_rise", drise, INH + 1);
    endtask

    task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] bits, output bit ok);
        int w;
        w = 0;
        ok = 1'b0;
        bits = '0;
        while (!(clk_line === 1'b1 && data_line === 1'b0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) return;
        ok = 1'b1;
        bits[0] = data_line;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (2) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) bits[i] = data_line;
            dev_clk = 1'b1;
            if (i == 11) dev_data = 1'b1;
            else repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack, input bit glitch);
        int d0;
        int e0;
        int w;
        logic [10:0] bits;
        bit ok;
        d0 = done_cnt;
        e0 = err_cnt;
        start_and_inhibit(b, glitch);
        dev_frame(11, ack, bits, ok);
        chk("request_seen", ok, 1);
        chk("frame_bits", bits, frame_model(b));
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
        chk("error_pulses", err_cnt - e0, ack ? 0 : 1);
        chk("idle_drives", {clk_ps2_drive_low, ps2_data_drive_low}, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int d0;
        int e0;
        int k;
        int w;
        logic [7:0] b;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_drives", {clk_ps2_drive_low, ps2_data_drive_low}, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_error", tx_error, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_byte(8'hED, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'h96, 1'b0, 1'b0);

        // Device never clocks: error after exactly TO cycles in the send phase.
        d0 = done_cnt;
        e0 = err_cnt;
        start_and_inhibit(8'h55, 1'b0);
        k = 0;
        while (tx_error !== 1'b1 && k < 2 * TO) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_drives", {clk_ps2_drive_low, ps2_data_drive_low}, 0);
        repeat (3) @(negedge clk);
        chk("timeout_error_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);

        // Reset while the device holds the clock low after fall 5.
        b = 8'hA5;
        d0 = done_cnt;
        e0 = err_cnt;
        start_and_inhibit(b, 1'b0);
        w = 0;
        while (!(clk_line === 1'b1 && data_line === 1'b0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        chk("drive_at_fall5", ps2_data_drive_low, {31'd0, ~b[4]});
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_reset_drives", {clk_ps2_drive_low, ps2_data_drive_low}, 0);
        chk("midframe_reset_busy", busy, 0);
        reset = 1'b0;
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        chk("midframe_reset_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        for (int i = 0; i < 4; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        end

        chk("done_error_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
